mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multi-cycle main control FSM that drives the MIPS ALU and datapath: it is the initiator side of the ALU's alu_control and operand-select interface. It sequences each instruction through fetch, decode, execute, memory and writeback, and consumes the ALU `zero` flag for branches. The block sits between the instruction register and memory handshake on one side and the datapath muxes, register file, PC and ALU on the other.

## Interface
- No parameters. Widths are fixed by the MIPS ISA.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26]; stable from DECODE until the next FETCH.
- `funct` in 6: IR[5:0]; same stability as `opcode`.
- `zero` in 1: ALU zero flag, combinational in the same cycle.
- `mem_ready` in 1: memory completes the access this cycle.
- `mem_read`, `mem_write` out 1: memory strobes.
- `iord` out 1: address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: IR load enable.
- `pc_en` out 1: PC load enable, equal to pc_write | (pc_write_cond & zero).
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 2: 00 = PC, 01 = A, 10 = zero-extended shamt.
- `alu_src_b` out 2: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `alu_control` out 4: 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 1001 sll (input2 << input1).
- `reg_write` out 1, `reg_dst` out 1 (1 = rd), `mem_to_reg` out 1.
- `illegal` out 1: one-cycle pulse on an unsupported instruction.
- `instr_count` out 32: retired-instruction counter.

## Operation
States are IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP and ILLEGAL. Any output not listed for a state is 0.

**Reset**
- Reset forces IDLE, all outputs 0 and `instr_count` = 0.
- IDLE → FETCH unconditionally.

**Per-state outputs and transitions**
- FETCH: mem_read=1, iord=0, src_a=00, src_b=01, add. ir_write and pc_write are both set to mem_ready, with pc_source=00. Stay in FETCH while !mem_ready; → DECODE when mem_ready.
- DECODE: src_a=00, src_b=11, add (computes the branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000000 with a supported funct → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDI_EXEC
  - 000010 (j) → JUMP
  - anything else → ILLEGAL
- Supported funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 000000 sll.
- MEM_ADDR: src_a=01, src_b=10, add. → MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Hold until mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. → FETCH.
- MEM_WRITE: mem_write=1, iord=1. Hold until mem_ready, then → FETCH.
- EXECUTE: src_b=00, alu_control from funct. src_a=10 for sll, otherwise 01. → ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. → FETCH.
- BRANCH: src_a=01, src_b=00, sub, pc_write_cond=1, pc_source=01. → FETCH.
- ADDI_EXEC: src_a=01, src_b=10, add. → ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0. → FETCH.
- JUMP: pc_write=1, pc_source=10. → FETCH.
- ILLEGAL: illegal=1. → FETCH. No PC rollback: the PC already points past the bad instruction.

**Retired-instruction counter**
- `instr_count` increments by 1 on the final cycle of MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP, and MEM_WRITE with mem_ready.
- It never increments on ILLEGAL.
- It wraps modulo 2^32.

## Timing
- All outputs are Moore-decoded from the state register, except for three Mealy terms:
  - `pc_en` uses the same-cycle `zero`.
  - FETCH `ir_write` and `pc_write` use `mem_ready`.
- Latency with zero-wait memory (mem_ready always 1):
  - lw 5 cycles; R-type, addi and sw 4 cycles; beq, j and illegal 3 cycles.
- Every cycle with mem_ready=0 in a memory state adds one cycle.
- mem_ready is ignored in non-memory states.
- Reset asserted mid-instruction aborts immediately: outputs go to 0 asynchronously, and no partial write may be issued in the reset cycle.

## Structure
- Shared package `mips_pkg`:
  - ALU control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLL.
  - Opcode constants and funct constants.
  - src_a, src_b and pc_source encodings.
  - State enum (4-bit).
- Sub-module `alu_funct_decoder`: combinational funct → {alu_control, is_shift, supported}. It is used by both DECODE (legality check) and EXECUTE (ALU operation select).

## Test plan
- Reset, release, mem_ready=1, R-type add (funct 100000) → IDLE, FETCH, DECODE, EXECUTE (alu_control=0010, src_a=01), ALU_WB (reg_write=1, reg_dst=1); instr_count=1.
- sll (funct 000000) → EXECUTE shows alu_control=1001, src_a=10, src_b=00.
- beq with zero=1, then beq with zero=0 → pc_en=1 then pc_en=0 in BRANCH; both retire, instr_count +2.
- lw with mem_ready low for 3 cycles in MEM_READ → MEM_READ held 4 cycles, mem_read=1, iord=1 throughout; 8 cycles total; MEM_WB has mem_to_reg=1.
- opcode 111111 → illegal pulses for exactly 1 cycle; instr_count unchanged; next state FETCH.
- reset asserted during MEM_WRITE → mem_write drops to 0 immediately; IDLE after release; instr_count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: ALU codes, opcodes,
// funct codes, datapath mux selects, FSM states and the registered control word.
package mips_pkg;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned COUNT_W    = 32;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b1001;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLL = 6'b000000;

  localparam logic [SEL_W-1:0] SRC_A_PC      = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_REG     = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_SHAMT   = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_REG     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_IMM_SH2 = 2'b11;
  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE, S_ALU_WB, S_BRANCH, S_ADDI_EXEC, S_ADDI_WB, S_JUMP, S_ILLEGAL
  } state_t;

  // Moore part of the control word; 'fetch' marks the cycle whose IR/PC writes wait on mem_ready.
  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  iord;
    logic                  fetch;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic [SEL_W-1:0]      pc_source;
    logic [SEL_W-1:0]      alu_src_a;
    logic [SEL_W-1:0]      alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  reg_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_funct_decoder.sv
// R-type funct decode: ALU operation, shift flag and legality of the funct code.
module alu_funct_decoder
  import mips_pkg::*;
(
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  is_shift,
  output logic                  supported
);

  always_comb begin
    alu_control = ALU_ADD;
    is_shift    = 1'b0;
    supported   = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLL: begin
        alu_control = ALU_SLL;
        is_shift    = 1'b1;
      end
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, ALU operation, memory strobes and a retired-instruction count.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic [SEL_W-1:0]      pc_source,
  output logic [SEL_W-1:0]      alu_src_a,
  output logic [SEL_W-1:0]      alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  illegal,
  output logic [COUNT_W-1:0]    instr_count
);

  state_t               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [ALU_CTRL_W-1:0] fn_alu;
  logic                 fn_shift;
  logic                 fn_ok;
  logic                 fetch_done;

  alu_funct_decoder u_funct_dec (
    .funct       (funct),
    .alu_control (fn_alu),
    .is_shift    (fn_shift),
    .supported   (fn_ok)
  );

  // Next state and retire counting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = fn_ok ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          count_d = count_q + COUNT_W'(1);
        end
      end
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        count_d = count_q + COUNT_W'(1);
      end
      S_ILLEGAL:   state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read    = 1'b1;
        ctrl_d.fetch       = 1'b1;
        ctrl_d.alu_src_a   = SRC_A_PC;
        ctrl_d.alu_src_b   = SRC_B_FOUR;
        ctrl_d.alu_control = ALU_ADD;
        ctrl_d.pc_source   = PC_SRC_ALU;
      end
      S_DECODE: begin
        ctrl_d.alu_src_a   = SRC_A_PC;
        ctrl_d.alu_src_b   = SRC_B_IMM_SH2;
        ctrl_d.alu_control = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_d.alu_src_a   = SRC_A_REG;
        ctrl_d.alu_src_b   = SRC_B_IMM;
        ctrl_d.alu_control = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_d.alu_src_a   = fn_shift ? SRC_A_SHAMT : SRC_A_REG;
        ctrl_d.alu_src_b   = SRC_B_REG;
        ctrl_d.alu_control = fn_alu;
      end
      S_ALU_WB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = SRC_A_REG;
        ctrl_d.alu_src_b     = SRC_B_REG;
        ctrl_d.alu_control   = ALU_SUB;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = PC_SRC_ALUOUT;
      end
      S_ADDI_WB: ctrl_d.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = PC_SRC_JUMP;
      end
      S_ILLEGAL: ctrl_d.illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
    end
  end

  // Fetch-cycle IR/PC writes and the branch PC enable see same-cycle mem_ready/zero.
  assign fetch_done  = ctrl_q.fetch & mem_ready;
  assign ir_write    = fetch_done;
  assign pc_en       = ctrl_q.pc_write | fetch_done | (ctrl_q.pc_write_cond & zero);

  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign iord        = ctrl_q.iord;
  assign pc_source   = ctrl_q.pc_source;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_control = ctrl_q.alu_control;
  assign reg_write   = ctrl_q.reg_write;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign illegal     = ctrl_q.illegal;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: latency table, hand-written corner sequences
// and randomized instruction streams checked against a per-instruction cycle script.
module tb_mips_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0]  pc_source, alu_src_a, alu_src_b;
  logic [3:0]  alu_control;
  logic        reg_write, reg_dst, mem_to_reg, illegal;
  logic [31:0] instr_count;

  mips_multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_en       (pc_en),
    .pc_source   (pc_source),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    int         ret;
    int         ill;
  } vec_t;

  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc;
  logic [31:0] model_count;

  function automatic out_t sample();
    out_t o;
    o.mem_read   = mem_read;
    o.mem_write  = mem_write;
    o.iord       = iord;
    o.ir_write   = ir_write;
    o.pc_en      = pc_en;
    o.pc_source  = pc_source;
    o.src_a      = alu_src_a;
    o.src_b      = alu_src_b;
    o.alu        = alu_control;
    o.reg_write  = reg_write;
    o.reg_dst    = reg_dst;
    o.mem_to_reg = mem_to_reg;
    o.illegal    = illegal;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // {supported, alu code} straight from the ISA funct table.
  function automatic logic [4:0] fn_model(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 4'b0010};
      6'h22:   return {1'b1, 4'b0110};
      6'h24:   return {1'b1, 4'b0000};
      6'h25:   return {1'b1, 4'b0001};
      6'h27:   return {1'b1, 4'b1100};
      6'h00:   return {1'b1, 4'b1001};
      default: return {1'b0, 4'b0000};
    endcase
  endfunction

  function automatic out_t fetch_exp(input logic rdy);
    out_t e = '0;
    e.mem_read = 1'b1;
    e.src_b    = 2'b01;
    e.alu      = 4'b0010;
    e.ir_write = rdy;
    e.pc_en    = rdy;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, compare at the falling edge.
  task automatic step(input string name, input out_t e, input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    cyc++;
    @(negedge clk);
    check(name, 64'(sample()), 64'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_count = '0;
    @(negedge clk);
    check("idle_outputs", 64'(sample()), 64'd0);
    check("idle_count", 64'(instr_count), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Whole-instruction cycle script; starts right after the edge that enters FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    out_t       e;
    logic [4:0] fm;
    opcode = op;
    funct  = fn;
    cyc    = 0;
    fm     = fn_model(fn);
    check("count", 64'(instr_count), 64'(model_count));
    for (int i = 0; i < fw; i++) step("fetch_wait", fetch_exp(1'b0), 1'b0, rbit());
    step("fetch", fetch_exp(1'b1), 1'b1, rbit());
    e = '0; e.src_b = 2'b11; e.alu = 4'b0010;
    step("decode", e, rbit(), rbit());
    if (op == 6'h23 || op == 6'h2B) begin
      e = '0; e.src_a = 2'b01; e.src_b = 2'b10; e.alu = 4'b0010;
      step("mem_addr", e, rbit(), rbit());
      e = '0; e.iord = 1'b1;
      if (op == 6'h23) e.mem_read = 1'b1; else e.mem_write = 1'b1;
      for (int i = 0; i < mw; i++) step("mem_wait", e, 1'b0, rbit());
      step("mem_access", e, 1'b1, rbit());
      if (op == 6'h23) begin
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        step("mem_wb", e, rbit(), rbit());
      end
      model_count++;
    end else if (op == 6'h00 && fm[4]) begin
      e = '0; e.src_a = (fn == 6'h00) ? 2'b10 : 2'b01; e.alu = fm[3:0];
      step("execute", e, rbit(), rbit());
      e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
      step("alu_wb", e, rbit(), rbit());
      model_count++;
    end else if (op == 6'h04) begin
      e = '0; e.src_a = 2'b01; e.alu = 4'b0110; e.pc_source = 2'b01; e.pc_en = z;
      step("branch", e, rbit(), z);
      model_count++;
    end else if (op == 6'h08) begin
      e = '0; e.src_a = 2'b01; e.src_b = 2'b10; e.alu = 4'b0010;
      step("addi_exec", e, rbit(), rbit());
      e = '0; e.reg_write = 1'b1;
      step("addi_wb", e, rbit(), rbit());
      model_count++;
    end else if (op == 6'h02) begin
      e = '0; e.pc_en = 1'b1; e.pc_source = 2'b10;
      step("jump", e, rbit(), rbit());
      model_count++;
    end else begin
      e = '0; e.illegal = 1'b1;
      step("illegal", e, rbit(), rbit());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[14];
    out_t       e;
    int         n, ill;
    logic       done;
    logic [31:0] c0;
    logic [5:0] ops[7];
    logic [5:0] fns[6];

    tbl[0]  = '{6'h00, 6'h20, 1'b0, 4, 1, 0};
    tbl[1]  = '{6'h00, 6'h22, 1'b0, 4, 1, 0};
    tbl[2]  = '{6'h00, 6'h24, 1'b0, 4, 1, 0};
    tbl[3]  = '{6'h00, 6'h25, 1'b0, 4, 1, 0};
    tbl[4]  = '{6'h00, 6'h27, 1'b0, 4, 1, 0};
    tbl[5]  = '{6'h00, 6'h00, 1'b0, 4, 1, 0};
    tbl[6]  = '{6'h00, 6'h2A, 1'b0, 3, 0, 1};
    tbl[7]  = '{6'h23, 6'h00, 1'b0, 5, 1, 0};
    tbl[8]  = '{6'h2B, 6'h00, 1'b0, 4, 1, 0};
    tbl[9]  = '{6'h04, 6'h00, 1'b1, 3, 1, 0};
    tbl[10] = '{6'h04, 6'h00, 1'b0, 3, 1, 0};
    tbl[11] = '{6'h08, 6'h00, 1'b0, 4, 1, 0};
    tbl[12] = '{6'h02, 6'h00, 1'b0, 3, 1, 0};
    tbl[13] = '{6'h3F, 6'h20, 1'b0, 3, 0, 1};
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00};

    // Zero-wait latency, retire and illegal-pulse table; each fetch is found by its strobes.
    do_reset();
    mem_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z;
      c0 = instr_count; n = 1; ill = 0; done = 1'b0;
      while (!done && n < 20) begin
        @(negedge clk);
        if (mem_read === 1'b1 && iord === 1'b0) done = 1'b1;
        else begin
          if (illegal === 1'b1) ill++;
          n++;
        end
      end
      check($sformatf("latency[%0d]", i), 64'(n), 64'(tbl[i].lat));
      check($sformatf("retire[%0d]", i), 64'(instr_count - c0), 64'(tbl[i].ret));
      check($sformatf("illegal_pulses[%0d]", i), 64'(ill), 64'(tbl[i].ill));
    end

    // Hand-written corner sequences.
    do_reset();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_instr(6'h00, 6'h00, 1'b0, 0, 0);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);
    check("lw_wait3_cycles", 64'(cyc), 64'd8);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    run_instr(6'h08, 6'h00, 1'b0, 2, 0);

    // Reset landing in the middle of a stalled store.
    opcode = 6'h2B; funct = '0;
    check("count_before_abort", 64'(instr_count), 64'(model_count));
    step("abort_fetch", fetch_exp(1'b1), 1'b1, 1'b0);
    e = '0; e.src_b = 2'b11; e.alu = 4'b0010;
    step("abort_decode", e, 1'b0, 1'b0);
    e = '0; e.src_a = 2'b01; e.src_b = 2'b10; e.alu = 4'b0010;
    step("abort_mem_addr", e, 1'b0, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    e = '0; e.mem_write = 1'b1; e.iord = 1'b1;
    check("abort_mem_write", 64'(sample()), 64'(e));
    reset = 1'b1;
    #1;
    model_count = '0;
    check("abort_outputs_zero", 64'(sample()), 64'd0);
    check("abort_count_zero", 64'(instr_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'(sample()), 64'd0);
    @(posedge clk);
    #1;
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);

    // Randomized instruction stream with random memory stalls.
    for (int k = 0; k < 200; k++) begin
      logic [5:0] op, fn;
      int sel;
      sel = $urandom_range(0, 8);
      op  = (sel < 7) ? ops[sel] : 6'($urandom);
      fn  = (sel == 8 || $urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(op, fn, rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    check("count_final", 64'(instr_count), 64'(model_count));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
